// File: rtl/pipe_adder_sub.sv
// ---------------------------------------------------------------------------
// pipe_adder_sub
//
// Pipelined adder/subtractor. The WIDTH-bit operation is split into
// NSTAGE = WIDTH/CHUNK chunks. Stage k adds chunk k, using the carry that
// stage k-1 registered. Each stage registers four things: the finished lower
// sum chunks, the upper A/B' chunks it has not yet used, the running carry
// and a valid bit. The last stage's registers drive the outputs directly.
// The whole pipeline freezes while the output is stalled.
//
// Subtraction is A + ~B + ~Cin, so Sub=1 gives A - B - Cin. For a subtract,
// Cout=1 means no borrow occurred.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B/Cin/Sub are valid this cycle
//   in_ready   block accepts an input this cycle (low only while stalled)
//   A, B       WIDTH-bit operands
//   Cin        carry-in (add) or borrow-in (subtract)
//   Sub        0 = add, 1 = subtract
//   out_valid  S/Cout/Ovf are valid
//   out_ready  downstream accepts the result
//   S          WIDTH-bit result
//   Cout       raw carry out of bit WIDTH-1
//   Ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipe_adder_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
   localparam int NSTAGE     = WIDTH / SAFE_CHUNK;

   if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_param
      $error("pipe_adder_sub: CHUNK must be >= 1 and divide WIDTH");
   end

   // A full output register that downstream is not taking freezes every
   // stage, so nothing is overwritten and nothing is dropped.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Operand conditioning: subtraction becomes addition of the complement.
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   assign b_eff = Sub ? ~B : B;
   assign c0    = Sub ? ~Cin : Cin;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int SW = (k + 1) * CHUNK;   // sum bits finished after this stage

      logic             v_in;
      logic             c_in;
      logic [CHUNK-1:0] a_chunk;
      logic [CHUNK-1:0] b_chunk;
      logic [CHUNK:0]   add;
      logic [SW-1:0]    sum_next;

      logic             vld_q;
      logic             cy_q;
      logic [SW-1:0]    sum_q;

      assign add = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_in};

      if (k == 0) begin : g_first
         assign v_in     = in_valid;
         assign c_in     = c0;
         assign a_chunk  = A[CHUNK-1:0];
         assign b_chunk  = b_eff[CHUNK-1:0];
         assign sum_next = add[CHUNK-1:0];
      end else begin : g_next
         assign v_in     = g_stage[k-1].vld_q;
         assign c_in     = g_stage[k-1].cy_q;
         assign a_chunk  = g_stage[k-1].g_fwd.a_q[CHUNK-1:0];
         assign b_chunk  = g_stage[k-1].g_fwd.b_q[CHUNK-1:0];
         assign sum_next = {add[CHUNK-1:0], g_stage[k-1].sum_q};
      end

      // NOTE: sequential state uses non-blocking (<=) so every stage samples
      // its predecessor's pre-edge value; blocking here would collapse the
      // pipeline into one cycle depending on block evaluation order.
      // NOTE: datapath registers are reset along with the valid bits because
      // S/Cout/Ovf must read zero during reset, and S/Cout come straight from
      // the last stage's sum and carry registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (!stall) begin
            vld_q <= v_in;
            cy_q  <= add[CHUNK];
            sum_q <= sum_next;
         end
      end

      if (k < NSTAGE - 1) begin : g_fwd
         // Upper operand chunks not yet consumed travel with the operation.
         localparam int UW = WIDTH - SW;

         logic [UW-1:0] a_up;
         logic [UW-1:0] b_up;
         logic [UW-1:0] a_q;
         logic [UW-1:0] b_q;

         if (k == 0) begin : g_src_in
            assign a_up = A[WIDTH-1:CHUNK];
            assign b_up = b_eff[WIDTH-1:CHUNK];
         end else begin : g_src_prev
            assign a_up = g_stage[k-1].g_fwd.a_q[WIDTH-k*CHUNK-1:CHUNK];
            assign b_up = g_stage[k-1].g_fwd.b_q[WIDTH-k*CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_up;
               b_q <= b_up;
            end
         end
      end else begin : g_last
         // Carry into the MSB equals a^b^s at that bit; overflow happens when
         // it differs from the carry out of the MSB.
         logic ovf_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (!stall) begin
               ovf_q <= a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ add[CHUNK-1] ^ add[CHUNK];
            end
         end
      end
   end

   assign out_valid = g_stage[NSTAGE-1].vld_q;
   assign S         = g_stage[NSTAGE-1].sum_q;
   assign Cout      = g_stage[NSTAGE-1].cy_q;
   assign Ovf       = g_stage[NSTAGE-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder_sub.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder_sub
//
// Bench for pipe_adder_sub. It drives a 16-bit/4-bit instance and a
// 32-bit/8-bit instance with directed vectors.
//
// For the 16-bit instance, a model computes each result with plain
// whole-width arithmetic and queues it when the operation is accepted. A
// compare process checks the outputs against the head of that queue on every
// falling edge. Directed tests also pin latency, stall, reset and the
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_pipe_adder_sub;

   typedef struct {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, s;
   logic        cin, sub, cout, ovf;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [31:0] a32, b32, s32;
   logic        cin32, sub32, cout32, ovf32;

   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   logic acc16  = 1'b0;
   res_t q[$];

   pipe_adder_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Cin(cin), .Sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(s), .Cout(cout), .Ovf(ovf)
   );

   pipe_adder_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .A(a32), .B(b32), .Cin(cin32), .Sub(sub32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .S(s32), .Cout(cout32), .Ovf(ovf32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Whole-width arithmetic. Overflow is defined from the operand and result
   // signs: it occurs when both operands share a sign and the result's sign
   // differs from it.
   function automatic res_t model(input logic [15:0] fa, input logic [15:0] fb,
                                  input logic fcin, input logic fsub);
      res_t        r;
      logic [15:0] bp;
      logic [16:0] full;
      bp     = fsub ? ~fb : fb;
      full   = {1'b0, fa} + {1'b0, bp} + {16'd0, (fsub ? ~fcin : fcin)};
      r.s    = full[15:0];
      r.cout = full[16];
      r.ovf  = (fa[15] == bp[15]) && (full[15] != fa[15]);
      return r;
   endfunction

   // Acceptance / delivery monitor: values are read before the edge updates.
   always @(posedge clk) begin
      acc16 = 1'b0;
      if (rst_n) begin
         if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_done++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            acc16 = 1'b1;
         end
      end
   end

   // Compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() == 0) begin
            check("idle_out_valid", {63'd0, out_valid}, 64'd0);
         end else if (out_valid) begin
            check("model_s",    {48'd0, s},    {48'd0, q[0].s});
            check("model_cout", {63'd0, cout}, {63'd0, q[0].cout});
            check("model_ovf",  {63'd0, ovf},  {63'd0, q[0].ovf});
         end
      end
   end

   // One operation into an empty pipe. Checks the accept edge, that nothing
   // shows before latency 4, and the hand-computed result at latency 4.
   task automatic single_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub,
                            input logic [15:0] es, input logic ec, input logic eo);
      in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
      @(posedge clk); #1;
      check({name, "_accept"}, {63'd0, acc16}, 64'd1);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check({name, "_early_valid"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_s"},    {48'd0, s},    {48'd0, es});
      check({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
      check({name, "_ovf"},  {63'd0, ovf},  {63'd0, eo});
   endtask

   // Present one operation and hold it until it is accepted (bounded).
   task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tcin, input logic tsub);
      int guard;
      guard    = 0;
      in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
      do begin
         @(posedge clk); #1;
         guard++;
      end while (!acc16 && guard < 50);
      if (!acc16) check("send_timeout", {63'd0, acc16}, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   logic [15:0] tab_a   [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'h1234, 16'hFFFF};
   logic [15:0] tab_b   [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'h4321, 16'h0000};
   logic        tab_cin [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        tab_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      int n_base;
      int cnt;
      int w;
      rst_n = 1'b1; out_ready = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

      // Reset state, observed without any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_s",         {48'd0, s},         64'd0);
      check("rst_cout",      {63'd0, cout},      64'd0);
      check("rst_ovf",       {63'd0, ovf},       64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
      #1 rst_n = 1'b1;

      // The first edge after release accepts; the hand-computed results follow.
      single_op("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      single_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      single_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      single_op("sub_brw",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
      single_op("ripple",    16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
      drain();

      // Operand extremes back to back, checked by the model.
      for (int i = 0; i < 6; i++) send(tab_a[i], tab_b[i], tab_cin[i], tab_sub[i]);
      drain();

      // Eight back-to-back inputs; output held off for 3 cycles once valid.
      n_base = n_done;
      fork
         for (int i = 0; i < 8; i++) send(16'(i), 16'h0100, 1'b0, 1'b0);
         begin
            w = 0;
            while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
            check("stall_wait_valid", {63'd0, out_valid}, 64'd1);
            out_ready = 1'b0;
            #1;
            check("stall_in_ready_now", {63'd0, in_ready}, 64'd0);
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
               check("stall_hold_s",     {48'd0, s},         64'h0100);
               check("stall_in_ready",   {63'd0, in_ready},  64'd0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("burst_delivered", 64'(n_done - n_base), 64'd8);

      // Reset pulsed between edges with operations in flight.
      for (int i = 0; i < 4; i++) send(16'h1111 * 16'(i + 1), 16'h0002, 1'b0, 1'b0);
      #2;
      check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      q.delete();
      #1;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_s",         {48'd0, s},         64'd0);
      check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
      #2 rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("post_rst_no_stale", 64'(cnt), 64'd0);

      // 32-bit instance with 8-bit chunks: carry ripples through all stages.
      in_valid32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; sub32 = 1'b0;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("w32_early_valid", {63'd0, out_valid32}, 64'd0);
      @(posedge clk); #1;
      check("w32_valid", {63'd0, out_valid32}, 64'd1);
      check("w32_s",     {32'd0, s32},         64'd0);
      check("w32_cout",  {63'd0, cout32},      64'd1);
      check("w32_ovf",   {63'd0, ovf32},       64'd0);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
